// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - bin, one bit per clock, LSB first.
// One full-subtractor cell plus a registered borrow; results registered at completion.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] r_q;
    logic             br_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;

    logic             x;
    logic             y;
    logic             diff_d;
    logic             br_d;
    logic [WIDTH-1:0] r_d;

    // Full-subtractor cell on the current LSBs and the next result shift value
    always_comb begin
        x      = a_q[0];
        y      = b_q[0];
        diff_d = x ^ y ^ br_q;
        br_d   = (~x & y) | (~(x ^ y) & br_q);
        r_d    = {diff_d, r_q[WIDTH-1:1]};
    end

    // Control FSM, operand/result shifters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        br_q    <= bin;
                        r_q     <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    r_q   <= r_d;
                    br_q  <= br_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        d_q     <= r_d;
                        bout_q  <= br_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        br_q    <= bin;
                        r_q     <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8).
// Reference result is plain (WIDTH+1)-bit arithmetic on the operands.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;

    int errs;
    int checks;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] av,
                                         input logic [W-1:0] bv,
                                         input logic binv);
        logic [W:0] r;
        r = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, binv};
        return r;
    endfunction

    // One operation: start pulse, optional mid-op poke, check latency and result.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic binv, input bit poke);
        logic [W:0] exp;
        int cyc;
        exp = model(av, bv, binv);
        @(negedge clk);
        start = 1'b1;
        a = av;
        b = bv;
        bin = binv;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 20) begin
            if (busy) cyc++;
            start = (poke && cyc == 3);
            if (cyc >= 3) begin
                a = W'($urandom);
                b = W'($urandom);
                bin = 1'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("busy_cycles", cyc, W);
        chk("busy_in_done", {31'd0, busy}, 32'd0);
        chk("d", {24'd0, d}, {24'd0, exp[W-1:0]});
        chk("bout", {31'd0, bout}, {31'd0, exp[W]});
        @(negedge clk);
        chk("done_single", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int cyc;
        int viol;
        errs = 0;
        checks = 0;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        bin = 1'b0;

        @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_d", {24'd0, d}, 32'd0);
        chk("rst_bout", {31'd0, bout}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(8'h05, 8'h03, 1'b0, 1'b0);
        do_op(8'h03, 8'h05, 1'b0, 1'b0);
        do_op(8'h00, 8'h00, 1'b1, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        do_op(8'h80, 8'h01, 1'b0, 1'b0);

        // Back-to-back with start held high
        @(negedge clk);
        start = 1'b1;
        a = 8'h10;
        b = 8'h01;
        bin = 1'b0;
        @(negedge clk);
        a = 8'h20;
        b = 8'h02;
        bin = 1'b1;
        cyc = 0;
        viol = 0;
        while (!done && cyc < 20) begin
            if (!busy) viol++;
            cyc++;
            @(negedge clk);
        end
        chk("b2b_d0", {24'd0, d}, 32'h0F);
        chk("b2b_bout0", {31'd0, bout}, 32'd0);
        chk("b2b_done0", {31'd0, done}, 32'd1);
        chk("b2b_busy0", {31'd0, busy}, 32'd0);
        cyc = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (!done && !busy) viol++;
        end while (!done && cyc < 20);
        chk("b2b_spacing", cyc, W + 1);
        chk("b2b_d1", {24'd0, d}, 32'h1D);
        chk("b2b_bout1", {31'd0, bout}, 32'd0);
        chk("b2b_busy_gaps", viol, 0);
        @(negedge clk);

        // Mid-operation start pulse and operand changes are ignored
        do_op(8'h05, 8'h03, 1'b0, 1'b1);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        start = 1'b1;
        a = 8'h90;
        b = 8'h11;
        bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_d", {24'd0, d}, 32'd0);
        chk("arst_bout", {31'd0, bout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        viol = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) viol++;
        end
        chk("arst_no_done", viol, 0);
        do_op(8'h90, 8'h11, 1'b0, 1'b0);

        // Random sweep
        for (int i = 0; i < 1000; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
